aor_key_loader: RTL and testbench

//  Activation-key delivery unit for AOR-locked datapaths such as the 16-bit error-tolerant adder.

---
 rtl/aor_lock_pkg.sv | 29 ++
 rtl/aor_chk_fold.sv | 20 ++
 rtl/aor_key_loader.sv | 155 +++++++++++++++
 tb/tb_aor_key_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aor_lock_pkg.sv
// Shared types and defaults for the AOR activation-key loader.
package aor_lock_pkg;

    localparam int KEY_W_DEF = 32;
    localparam int CHK_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_KEY = 3'd1,
        S_LOAD_CHK = 3'd2,
        S_CHECK    = 3'd3,
        S_ACTIVE   = 3'd4,
        S_FAIL     = 3'd5,
        S_LOCKOUT  = 3'd6
    } ldr_state_t;

    // Reference fold at the default widths: bit i is the XOR of every key bit j with j % CHK_W == i.
    function automatic logic [CHK_W_DEF-1:0] chk_fold(input logic [KEY_W_DEF-1:0] key);
        logic [CHK_W_DEF-1:0] f;
        f = '0;
        for (int i = 0; i < CHK_W_DEF; i++) begin
            for (int k = 0; k < KEY_W_DEF / CHK_W_DEF; k++) begin
                f[i] = f[i] ^ key[k*CHK_W_DEF+i];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/aor_chk_fold.sv
// Combinational XOR fold of a KEY_W key down to a CHK_W checksum.
module aor_chk_fold #(
    parameter int KEY_W = 32,
    parameter int CHK_W = 8
) (
    input  logic [KEY_W-1:0] key_i,
    output logic [CHK_W-1:0] fold_o
);

    // XOR each CHK_W-wide slice of the key into the result.
    always_comb begin
        fold_o = '0;
        for (int i = 0; i < CHK_W; i++) begin
            for (int k = 0; k < KEY_W / CHK_W; k++) begin
                fold_o[i] = fold_o[i] ^ key_i[k*CHK_W+i];
            end
        end
    end

endmodule

// File: rtl/aor_key_loader.sv
// Serial activation-key loader: shifts in key and checksum, verifies, then drives the keyinput bus.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no key held, bus carries decoy
// S_LOAD_KEY | shifting in KEY_W key bits, LSB first
// S_LOAD_CHK | shifting in CHK_W checksum bits, LSB first
// S_CHECK    | one cycle: compare folded key against checksum
// S_ACTIVE   | verified key published on keyinput_o
// S_FAIL     | checksum mismatch, decoy on bus, key_err_o set
// S_LOCKOUT  | MAX_FAIL mismatches seen; absorbing until rst_n
//
// Outputs are registered from the current state, so the published key and the
// error/lockout flags appear one edge after the state is entered. start_i and
// clear_i drop the bus to decoy on the same edge they are taken.
module aor_key_loader
    import aor_lock_pkg::*;
#(
    parameter int               KEY_W     = KEY_W_DEF,
    parameter int               CHK_W     = CHK_W_DEF,
    parameter logic [KEY_W-1:0] DECOY_KEY = '0,
    parameter int               MAX_FAIL  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    output logic             bit_ready_o,
    output logic [KEY_W-1:0] keyinput_o,
    output logic             key_valid_o,
    output logic             key_err_o,
    output logic             lockout_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    ldr_state_t       state_q, state_d;
    logic [KEY_W-1:0] key_sh_q, key_sh_d;
    logic [CHK_W-1:0] chk_sh_q, chk_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       fail_cnt_q, fail_cnt_d;
    logic [KEY_W-1:0] keyinput_q, keyinput_d;
    logic             key_valid_q, key_valid_d;
    logic             key_err_q, key_err_d;
    logic             lockout_q, lockout_d;
    logic [CHK_W-1:0] fold;
    logic             xfer;
    logic             start_ok;

    aor_chk_fold #(.KEY_W(KEY_W), .CHK_W(CHK_W)) u_fold (
        .key_i  (key_sh_q),
        .fold_o (fold)
    );

    assign bit_ready_o = ((state_q == S_LOAD_KEY) || (state_q == S_LOAD_CHK)) && !clear_i;
    assign busy_o      = (state_q == S_LOAD_KEY) || (state_q == S_LOAD_CHK) || (state_q == S_CHECK);
    assign keyinput_o  = keyinput_q;
    assign key_valid_o = key_valid_q;
    assign key_err_o   = key_err_q;
    assign lockout_o   = lockout_q;
    assign xfer        = bit_valid_i && bit_ready_o;
    assign start_ok    = start_i && ((state_q == S_IDLE) || (state_q == S_ACTIVE) || (state_q == S_FAIL));

    // Next-state, shift-register and output computation; clear beats start beats bit transfer.
    always_comb begin
        state_d     = state_q;
        key_sh_d    = key_sh_q;
        chk_sh_d    = chk_sh_q;
        cnt_d       = cnt_q;
        fail_cnt_d  = fail_cnt_q;
        keyinput_d  = keyinput_q;
        key_valid_d = key_valid_q;
        key_err_d   = key_err_q;
        lockout_d   = lockout_q;
        if (state_q == S_LOCKOUT) begin
            key_sh_d    = '0;
            keyinput_d  = DECOY_KEY;
            key_valid_d = 1'b0;
            key_err_d   = 1'b1;
            lockout_d   = 1'b1;
        end else if (clear_i || start_ok) begin
            state_d     = clear_i ? S_IDLE : S_LOAD_KEY;
            key_sh_d    = '0;
            chk_sh_d    = '0;
            cnt_d       = '0;
            keyinput_d  = DECOY_KEY;
            key_valid_d = 1'b0;
            key_err_d   = 1'b0;
        end else begin
            case (state_q)
                S_LOAD_KEY: if (xfer) begin
                    key_sh_d = {bit_i, key_sh_q[KEY_W-1:1]};
                    if (cnt_q == CNT_W'(KEY_W - 1)) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_CHK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_LOAD_CHK: if (xfer) begin
                    chk_sh_d = {bit_i, chk_sh_q[CHK_W-1:1]};
                    if (cnt_q == CNT_W'(CHK_W - 1)) begin
                        cnt_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (fold == chk_sh_q) begin
                        state_d = S_ACTIVE;
                    end else begin
                        fail_cnt_d = (fail_cnt_q == 4'hF) ? fail_cnt_q : fail_cnt_q + 4'd1;
                        state_d    = ((fail_cnt_q + 4'd1) == 4'(MAX_FAIL)) ? S_LOCKOUT : S_FAIL;
                    end
                end
                S_ACTIVE: begin
                    keyinput_d  = key_sh_q;
                    key_valid_d = 1'b1;
                end
                S_FAIL: key_err_d = 1'b1;
                default: ;
            endcase
        end
    end

    // State and datapath registers; reset returns to IDLE with the decoy on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_sh_q    <= '0;
            chk_sh_q    <= '0;
            cnt_q       <= '0;
            fail_cnt_q  <= '0;
            keyinput_q  <= DECOY_KEY;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_sh_q    <= key_sh_d;
            chk_sh_q    <= chk_sh_d;
            cnt_q       <= cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            keyinput_q  <= keyinput_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
            lockout_q   <= lockout_d;
        end
    end

endmodule

// File: tb/tb_aor_key_loader.sv
// Scoreboard bench for aor_key_loader: loads push expected outcomes, a negedge monitor pops them.
module tb_aor_key_loader;

    localparam int K_VALID = 0;
    localparam int K_ERR   = 1;
    localparam int K_LOCK  = 2;

    typedef struct {
        int          kind;
        logic [31:0] key;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        bit_i = 1'b0;
    logic        bit_valid_i = 1'b0;
    logic        bit_ready_o;
    logic [31:0] keyinput_o;
    logic        key_valid_o;
    logic        key_err_o;
    logic        lockout_o;
    logic        busy_o;

    int   cyc = 0;
    int   last_edge = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;
    exp_t exp_q[$];

    aor_key_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .bit_ready_o (bit_ready_o),
        .keyinput_o  (keyinput_o),
        .key_valid_o (key_valid_o),
        .key_err_o   (key_err_o),
        .lockout_o   (lockout_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Present one bit and hold it until the loader takes it.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        bit_i = b;
        bit_valid_i = 1'b1;
        while (!bit_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 last_edge = cyc;
        @(negedge clk);
        bit_valid_i = 1'b0;
    endtask

    task automatic load(input logic [31:0] key, input logic [7:0] chk, input int gap_max, input int kind);
        exp_t e;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send_bit(key[i]);
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            send_bit(chk[i]);
            if (gap_max > 0 && i < 7) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
        e.kind = kind;
        e.key  = (kind == K_VALID) ? key : 32'h0;
        e.cyc  = last_edge + 2;
        exp_q.push_back(e);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_key"},   keyinput_o, 32'h0);
        check({tag, "_valid"}, 32'(key_valid_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o), 32'd0);
        check({tag, "_ready"}, 32'(bit_ready_o), 32'd0);
    endtask

    // Monitor: on each rising outcome flag, pop the expected outcome and compare.
    initial begin
        logic pv_v, pv_e, pv_l;
        exp_t e;
        int   kind;
        pv_v = 1'b0; pv_e = 1'b0; pv_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                kind = -1;
                if (lockout_o && !pv_l)      kind = K_LOCK;
                else if (key_err_o && !pv_e) kind = K_ERR;
                else if (key_valid_o && !pv_v) kind = K_VALID;
                if (kind >= 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", 32'(kind), 32'(e.kind));
                        check("event_cycle", 32'(cyc), 32'(e.cyc));
                        check("event_keyinput", keyinput_o, e.key);
                        check("event_key_valid", 32'(key_valid_o), (e.kind == K_VALID) ? 32'd1 : 32'd0);
                    end
                end
            end
            pv_v = key_valid_o; pv_e = key_err_o; pv_l = lockout_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_err",  32'(key_err_o), 32'd0);
        check("reset_lock", 32'(lockout_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: good load
        load(32'h1234_5678, 8'h08, 0, K_VALID);
        check("t1_busy", 32'(busy_o), 32'd0);
        check("t1_key", keyinput_o, 32'h1234_5678);
        check("t1_valid", 32'(key_valid_o), 32'd1);

        // 2: bad checksum, then recovery (fail count now 1)
        load(32'h1234_5678, 8'h09, 0, K_ERR);
        check("t2_err", 32'(key_err_o), 32'd1);
        check("t2_key", keyinput_o, 32'h0);
        load(32'h1234_5678, 8'h08, 0, K_VALID);
        check("t2_err_cleared", 32'(key_err_o), 32'd0);
        check("t2_key_good", keyinput_o, 32'h1234_5678);

        // 4: gapped transfers give the same result
        load(32'h1234_5678, 8'h08, 5, K_VALID);
        check("t4_key", keyinput_o, 32'h1234_5678);
        load(32'hA5C3_0FF1, 8'h98, 3, K_VALID);
        check("t4_key2", keyinput_o, 32'hA5C3_0FF1);

        // 5: clear on bit 17 together with a valid bit
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 17; i++) send_bit(1'b1);
        clear_i = 1'b1;
        bit_i = 1'b1;
        bit_valid_i = 1'b1;
        #1 check("t5_ready_under_clear", 32'(bit_ready_o), 32'd0);
        @(posedge clk);
        #1 check_idle_outputs("t5_after_clear");
        @(negedge clk);
        clear_i = 1'b0;
        bit_valid_i = 1'b0;
        load(32'h1234_5678, 8'h08, 0, K_VALID);
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check_idle_outputs("t5_clear_active");

        // 6: reset mid LOAD_CHK and while ACTIVE
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 35; i++) send_bit(1'b0);
        check("t6_busy_before", 32'(busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("t6_rst_load");
        @(negedge clk);
        rst_n = 1'b1;
        load(32'h1234_5678, 8'h08, 0, K_VALID);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("t6_rst_active");
        @(negedge clk);
        rst_n = 1'b1;

        // 3: three new failures lock out (fail count was cleared by reset)
        load(32'h0000_0001, 8'h00, 0, K_ERR);
        load(32'h0000_0001, 8'h00, 0, K_ERR);
        load(32'h0000_0001, 8'h00, 0, K_LOCK);
        check("t3_lock", 32'(lockout_o), 32'd1);
        check_idle_outputs("t3_locked");
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        bit_valid_i = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_ready_valid_hi", 32'(bit_ready_o), 32'd0);
        bit_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_lock_held", 32'(lockout_o), 32'd1);
        check_idle_outputs("t3_after_pokes");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
